// File: rtl/approx_err_pkg.sv
// Shared types, default widths and saturating helpers for the approximate-adder error monitor.
// Optional signed-bias accumulation is enabled with APPROX_ERR_BIAS_EN.
package approx_err_pkg;

    localparam int DEF_N     = 16;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_ACC_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned add clamped at 2^w-1; operands are zero-extended into 64 bits (w <= 64).
    function automatic logic [63:0] sat_add_u(input logic [63:0] acc,
                                              input logic [63:0] inc,
                                              input int          w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

    // Signed add clamped symmetrically at +/-(2^(w-1)-1); operands are sign-extended into 64 bits.
    function automatic logic [63:0] sat_add_s(input logic [63:0] acc,
                                              input logic [63:0] inc,
                                              input int          w);
        logic signed [64:0] sum;
        logic signed [64:0] lim;
        sum = $signed({acc[63], acc}) + $signed({inc[63], inc});
        lim = (65'sd1 <<< (w - 1)) - 65'sd1;
        if (sum > lim)
            sum = lim;
        else if (sum < -lim)
            sum = -lim;
        return sum[63:0];
    endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Combinational exact-sum, error-distance and error-flag unit for one sample.
// The signed difference output exists only when APPROX_ERR_BIAS_EN is defined.
module approx_err_dist #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] s,
    output logic [N-1:0] ed,
    output logic         err
`ifdef APPROX_ERR_BIAS_EN
    ,
    output logic [N:0]   diff
`endif
);

    logic [N-1:0]      exact;
    logic signed [N:0] d;

    assign exact = a + b;
    // N+1-bit signed difference, so the magnitude never wraps and fits in N bits
    assign d     = $signed({1'b0, s}) - $signed({1'b0, exact});
    assign ed    = d[N] ? N'(-d) : N'(d);
    assign err   = (s != exact);

`ifdef APPROX_ERR_BIAS_EN
    assign diff = d;
`endif

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Streaming error-metric engine: FSM, 2-stage sample pipeline and saturating stat accumulators.
// Define APPROX_ERR_BIAS_EN to add the signed-error accumulator output sum_sed.
module approx_adder_err_monitor
    import approx_err_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [N-1:0]     in_s,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [N-1:0]     max_ed
`ifdef APPROX_ERR_BIAS_EN
    ,
    output logic signed [ACC_W-1:0] sum_sed
`endif
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic [N-1:0] ed;
        logic         err;
`ifdef APPROX_ERR_BIAS_EN
        logic [N:0]   diff;
`endif
    } s1_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_lat, accepted;
    logic [STAGES:1]  vld_pipe;
    s1_t              s1_q;
    logic             xfer, start_ok;
    logic [N-1:0]     dist_ed;
    logic             dist_err;
`ifdef APPROX_ERR_BIAS_EN
    logic [N:0]       dist_diff;
`endif

    approx_err_dist #(.N(N)) u_dist (
        .a   (in_a),
        .b   (in_b),
        .s   (in_s),
        .ed  (dist_ed),
        .err (dist_err)
`ifdef APPROX_ERR_BIAS_EN
        ,
        .diff(dist_diff)
`endif
    );

    assign in_ready = (state == RUN) && (accepted < num_lat);
    assign xfer     = in_valid && in_ready;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            // leave RUN on the same edge that accepts the last sample
            RUN:        if (accepted + CNT_W'(xfer) == num_lat) state_nxt = DRAIN;
            DRAIN:      if (vld_pipe == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            num_lat  <= '0;
            accepted <= '0;
            vld_pipe <= '0;
            s1_q     <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
            if (start_ok) begin
                num_lat  <= num_samples;
                accepted <= '0;
            end else if (xfer) begin
                accepted <= accepted + CNT_W'(1);
            end
            if (xfer) begin
                s1_q.ed   <= dist_ed;
                s1_q.err  <= dist_err;
`ifdef APPROX_ERR_BIAS_EN
                s1_q.diff <= dist_diff;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
`ifdef APPROX_ERR_BIAS_EN
            sum_sed    <= '0;
`endif
        end else if (start_ok) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
`ifdef APPROX_ERR_BIAS_EN
            sum_sed    <= '0;
`endif
        end else if (vld_pipe[1]) begin
            // counters are bounded by num_samples, so plain increments cannot wrap
            sample_cnt <= sample_cnt + CNT_W'(1);
            err_cnt    <= err_cnt + CNT_W'(s1_q.err);
            sum_ed     <= ACC_W'(sat_add_u(64'(sum_ed), 64'(s1_q.ed), ACC_W));
            if (s1_q.ed > max_ed)
                max_ed <= s1_q.ed;
`ifdef APPROX_ERR_BIAS_EN
            sum_sed    <= ACC_W'(sat_add_s(64'(sum_sed), 64'($signed(s1_q.diff)), ACC_W));
`endif
        end
    end

endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
Synthesizable, streaming error-metric engine for approximate adders. It is the hardware successor to the simulation-only error-rate / MED bench.
- Accepts operand pairs plus the approximate sum from a DUT adder through a valid/ready handshake.
- Computes the exact modulo-2^N sum internally.
- Accumulates error count, total error distance, max error distance and sample count over a programmable run length.
- Sits beside any N-bit approximate adder (HERLOA and similar families) in on-chip/FPGA characterisation harnesses. MED and NMED are derived by software from the outputs.

Parameters:
N, 16, operand/sum width
CNT_W, 32, width of sample counters and num_samples
ACC_W, 48, width of error-distance accumulators (must be >= N)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear stats, latch num_samples, begin run
num_samples  in  CNT_W  run length, latched on start
in_valid  in  1  sample valid
in_ready  out  1  block accepts sample this cycle
in_a  in  N  operand A
in_b  in  N  operand B
in_s  in  N  approximate sum from DUT
busy  out  1  state is RUN or DRAIN
done  out  1  level, high in DONE
sample_cnt  out  CNT_W  samples accumulated
err_cnt  out  CNT_W  samples with in_s != exact
sum_ed  out  ACC_W  sum of error distances, saturating
max_ed  out  N  largest error distance seen

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n). Reset forces state IDLE and all outputs/counters/accumulators to 0, including in_ready, busy and done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN.
  - RUN --(accepted count == latched num_samples)--> DRAIN.
  - DRAIN --(both pipeline stages empty)--> DONE.
  - DONE --start--> RUN.
  - start with num_samples == 0: RUN -> DRAIN -> DONE with all stats 0; done rises 3 cycles after start.
- start is ignored in RUN/DRAIN. start in IDLE or DONE clears sample_cnt, err_cnt, sum_ed, max_ed (and sum_sed) in the same edge.
- Handshake:
  - in_ready = (state == RUN) && (accepted < num_samples). It is registered-state based, with no combinational path from in_valid.
  - A sample transfers when in_valid && in_ready. Bubbles are allowed; no backpressure from downstream.
- Pipeline: 2 stages, per-stage valid bit.
  - S1 registers exact = (in_a + in_b) mod 2^N and ed = |in_s - exact|, where the difference is taken as N+1-bit signed and ed is its N-bit magnitude (non-modular, so ed <= 2^N-1). S1 also registers the error flag (in_s != exact).
  - S2 updates the stats. Stats reflect a sample 2 cycles after its transfer edge.
- Arithmetic:
  - sum_ed saturates at 2^ACC_W-1.
  - err_cnt and sample_cnt cannot exceed num_samples, so they do not wrap.
  - max_ed updates when ed > max_ed.
- DONE holds all stats stable until the next start or reset.
- Reset mid-run aborts immediately; the partial run is discarded.
- Simultaneous transfer of the last sample and the RUN->DRAIN transition: the sample is counted, and in_ready drops the following cycle.

Optional Feature:
Macro: APPROX_ERR_BIAS_EN
- Defined: adds output sum_sed (signed, ACC_W bits), which accumulates the signed error in_s - exact with symmetric saturation at ±(2^(ACC_W-1)-1). It is cleared on start and 0 on reset. This gives the mean error bias.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package approx_err_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Saturating-add function.
  - Default width constants.
- One sub-module: approx_err_dist, the combinational exact-sum plus |difference| plus error-flag unit. It is parametrised by N and instantiated in S1.
- The top holds the FSM, pipeline valids and accumulators.

Test Plan:
- Exact DUT model (in_s = a+b), num_samples=4 -> done; sample_cnt=4, err_cnt=0, sum_ed=0, max_ed=0.
- Samples (3,5,s=0), (0xFFFF,0x0001,s=0x0000), (1,1,s=0xFFFF), num_samples=3 -> err_cnt=2, sum_ed=8+0xFFFD=0x10005, max_ed=0xFFFD; bias build sum_sed=-8+0xFFFD=0xFFF5.
- num_samples=0 -> no transfer; done high 3 cycles after start, all stats 0.
- num_samples=5 with in_valid toggling every other cycle -> exactly 5 transfers; in_ready low after the 5th; stats equal the scoreboard; done 2 cycles after the last accumulate edge.
- ACC_W=N=16, 3 samples each with ed=0xFFFF -> sum_ed saturates at 0xFFFF, err_cnt=3.
- rst_n low after 2 of 6 samples -> all outputs 0 asynchronously, IDLE; a new start with num_samples=2 completes cleanly with sample_cnt=2.
